// File: rtl/join4_pkg.sv
// Shared types and constants for the 4-way join controller.
package join4_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    FIRE,
    ABORT
  } join4_state_e;

  localparam logic [3:0] ALL_ARR = 4'hF;

  // A join can complete once every channel is either arrived or masked,
  // provided at least one channel actually takes part.
  function automatic logic join_done(logic [3:0] arr_next, logic [3:0] msk);
    return ((arr_next | msk) == ALL_ARR) && (msk != ALL_ARR);
  endfunction

endpackage

// File: rtl/join4_tmo.sv
// Loadable up-counter with clear/enable and a terminal-count flag.
module join4_tmo #(
  parameter int unsigned Width   = 5,
  parameter int unsigned TermCnt = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [Width-1:0] ld_val_i,
  output logic             tc_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (ld_i) begin
      cnt_q <= ld_val_i;
    end else if (en_i) begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

  assign tc_o = (cnt_q == Width'(TermCnt));

endmodule

// File: rtl/join4_ctrl.sv
// 4-way rendezvous: collects one token per enabled channel, fires one joined
// token, and aborts an incomplete join after a timeout.
module join4_ctrl
  import join4_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 16,
  parameter int unsigned TMO_W      = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             ck,
  input  logic             nrst,
  input  logic [3:0]       i_vld,
  output logic [3:0]       i_rdy,
  input  logic [3:0]       mask,
  output logic             q_vld,
  input  logic             q_rdy,
  output logic             err,
  output logic [3:0]       arr,
  output logic [CNT_W-1:0] fcnt
);

  join4_state_e     state_q;
  logic [3:0]       arr_q;
  logic [CNT_W-1:0] fcnt_q;
  logic             q_vld_q;
  logic             err_q;

  logic [3:0] hs;
  logic [3:0] arr_next;
  logic       done;
  logic       tmo_tc;
  logic       tmo_hit;
  logic       collecting;

  assign collecting = (state_q == COLLECT);
  assign i_rdy      = collecting ? (~arr_q & ~mask) : 4'h0;
  assign hs         = i_vld & i_rdy;
  assign arr_next   = arr_q | hs;
  assign done       = join_done(arr_next, mask);

  // Counter only runs while a join is partially collected.
  generate
    if (TMO_CYCLES != 0) begin : g_tmo
      join4_tmo #(
        .Width   (TMO_W),
        .TermCnt (TMO_CYCLES - 1)
      ) u_tmo (
        .clk_i    (ck),
        .rst_ni   (nrst),
        .clr_i    (!collecting || (arr_q == 4'h0)),
        .en_i     (collecting && (arr_q != 4'h0)),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .tc_o     (tmo_tc)
      );
    end else begin : g_no_tmo
      assign tmo_tc = 1'b0;
    end
  endgenerate

  assign tmo_hit = tmo_tc && (arr_q != 4'h0);

  always_ff @(posedge ck or negedge nrst) begin
    if (!nrst) begin
      state_q <= COLLECT;
      arr_q   <= 4'h0;
      fcnt_q  <= '0;
      q_vld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          arr_q <= arr_next;
          // Completion has priority over a timeout landing in the same cycle.
          if (done) begin
            state_q <= FIRE;
            q_vld_q <= 1'b1;
          end else if (tmo_hit) begin
            state_q <= ABORT;
            err_q   <= 1'b1;
          end
        end
        FIRE: begin
          if (q_rdy) begin
            state_q <= COLLECT;
            q_vld_q <= 1'b0;
            arr_q   <= 4'h0;
            fcnt_q  <= fcnt_q + CNT_W'(1);
          end
        end
        ABORT: begin
          state_q <= COLLECT;
          arr_q   <= 4'h0;
        end
        default: begin
          state_q <= COLLECT;
          arr_q   <= 4'h0;
          q_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign q_vld = q_vld_q;
  assign err   = err_q;
  assign arr   = arr_q;
  assign fcnt  = fcnt_q;

  a_err_pulse: assert property (@(posedge ck) disable iff (!nrst) err_q |=> !err_q);
  a_qvld_hold: assert property (@(posedge ck) disable iff (!nrst)
                                (q_vld_q && !q_rdy) |=> q_vld_q);

endmodule

// File: tb/tb_join4_ctrl.sv
// Bench for join4_ctrl: directed stimulus with a queue-based scoreboard of
// expected joined tokens and abort pulses.
module tb_join4_ctrl;

  logic       ck;
  logic       nrst;
  logic [3:0] i_vld;
  logic [3:0] i_rdy;
  logic [3:0] mask;
  logic       q_vld;
  logic       q_rdy;
  logic       err;
  logic [3:0] arr;
  logic [7:0] fcnt;

  join4_ctrl #(
    .TMO_CYCLES (16),
    .TMO_W      (5),
    .CNT_W      (8)
  ) dut (
    .ck    (ck),
    .nrst  (nrst),
    .i_vld (i_vld),
    .i_rdy (i_rdy),
    .mask  (mask),
    .q_vld (q_vld),
    .q_rdy (q_rdy),
    .err   (err),
    .arr   (arr),
    .fcnt  (fcnt)
  );

  typedef struct {
    bit         is_err;
    int         fcnt;
    logic [3:0] arr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   exp_fcnt;
  int   cyc_arr;
  logic prev_qv = 1'b0;
  logic prev_qr = 1'b0;

  initial ck = 1'b0;
  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(bit is_err, int f, logic [3:0] a, int c);
    exp_t e;
    e.is_err = is_err;
    e.fcnt   = f;
    e.arr    = a;
    e.cyc    = c;
    sb.push_back(e);
  endtask

  task automatic pop_check(bit is_err);
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_%s: got event at cycle %0d expected none",
               is_err ? "err" : "fire", cyc);
    end else begin
      e = sb.pop_front();
      if (e.is_err != is_err || e.fcnt != 32'(fcnt) || e.arr !== arr ||
          (e.cyc >= 0 && e.cyc != cyc)) begin
        n_bad++;
        $display("FAIL sb_event: got err=%0d fcnt=%0d arr=%b cyc=%0d expected err=%0d fcnt=%0d arr=%b cyc=%0d",
                 is_err, fcnt, arr, cyc, e.is_err, e.fcnt, e.arr, e.cyc);
      end
    end
  endtask

  // Monitor: decoupled from stimulus, checks every output token and abort.
  always @(negedge ck) begin
    if (nrst) begin
      if (prev_qv && !prev_qr) begin
        n_vec++;
        if (!q_vld) begin
          n_bad++;
          $display("FAIL q_vld_hold: got q_vld=0 expected 1 at cycle %0d", cyc);
        end
      end
      if (q_vld && q_rdy) pop_check(1'b0);
      if (err) pop_check(1'b1);
      prev_qv = q_vld;
      prev_qr = q_rdy;
    end else begin
      prev_qv = 1'b0;
      prev_qr = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst  = 1'b0;
    i_vld = 4'h0;
    mask  = 4'h0;
    q_rdy = 1'b1;
    exp_fcnt = 0;
    repeat (3) tick();
    nrst = 1'b1;
    tick();

    // Reset state
    chk("rst_q_vld", 32'(q_vld), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_arr", 32'(arr), 32'h0);
    chk("rst_fcnt", 32'(fcnt), 32'd0);
    chk("rst_i_rdy", 32'(i_rdy), 32'hF);

    // T2: all four in one cycle
    i_vld = 4'hF;
    push_exp(1'b0, exp_fcnt, 4'hF, -1);
    tick();
    i_vld = 4'h0;
    chk("t2_q_vld", 32'(q_vld), 32'd1);
    chk("t2_i_rdy_fire", 32'(i_rdy), 32'h0);
    tick();
    exp_fcnt++;
    chk("t2_q_vld_drop", 32'(q_vld), 32'd0);
    chk("t2_fcnt", 32'(fcnt), 32'(exp_fcnt));
    chk("t2_i_rdy_rearm", 32'(i_rdy), 32'hF);

    // T3: staggered arrivals ch0,2,1,3 with backpressure
    q_rdy = 1'b0;
    i_vld = 4'b0001; tick(); i_vld = 4'h0;
    chk("t3_i_rdy_a", 32'(i_rdy), 32'b1110);
    chk("t3_arr_a", 32'(arr), 32'b0001);
    i_vld = 4'b0100; tick(); i_vld = 4'h0;
    chk("t3_i_rdy_b", 32'(i_rdy), 32'b1010);
    i_vld = 4'b0010; tick(); i_vld = 4'h0;
    chk("t3_i_rdy_c", 32'(i_rdy), 32'b1000);
    push_exp(1'b0, exp_fcnt, 4'hF, -1);
    i_vld = 4'b1000; tick(); i_vld = 4'h0;
    chk("t3_q_vld", 32'(q_vld), 32'd1);
    chk("t3_i_rdy_fire", 32'(i_rdy), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t3_bp_fcnt", 32'(fcnt), 32'(exp_fcnt));
    end
    tick();
    q_rdy = 1'b1;
    tick();
    exp_fcnt++;
    chk("t3_fcnt", 32'(fcnt), 32'(exp_fcnt));
    chk("t3_q_vld_drop", 32'(q_vld), 32'd0);

    // T1: asynchronous reset while in FIRE
    q_rdy = 1'b0;
    i_vld = 4'hF; tick(); i_vld = 4'h0;
    chk("t1_pre_q_vld", 32'(q_vld), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("t1_q_vld", 32'(q_vld), 32'd0);
    chk("t1_arr", 32'(arr), 32'h0);
    chk("t1_fcnt", 32'(fcnt), 32'd0);
    chk("t1_err", 32'(err), 32'd0);
    tick();
    nrst = 1'b1;
    q_rdy = 1'b1;
    exp_fcnt = 0;
    tick();
    chk("t1_i_rdy", 32'(i_rdy), 32'hF);

    // T6: 256 joins wrap the fire counter
    for (int j = 0; j < 256; j++) begin
      push_exp(1'b0, j, 4'hF, -1);
      i_vld = 4'hF; tick(); i_vld = 4'h0;
      tick();
      if (j == 254) chk("t6_fcnt_255", 32'(fcnt), 32'd255);
    end
    chk("t6_fcnt_wrap", 32'(fcnt), 32'd0);

    // T4: timeout with only ch0/ch1
    i_vld = 4'b0011; tick(); i_vld = 4'h0;
    cyc_arr = cyc;
    push_exp(1'b1, 0, 4'b0011, cyc_arr + 16);
    chk("t4_arr", 32'(arr), 32'b0011);
    repeat (16) tick();
    chk("t4_err", 32'(err), 32'd1);
    tick();
    chk("t4_err_drop", 32'(err), 32'd0);
    chk("t4_arr_clr", 32'(arr), 32'h0);
    chk("t4_fcnt", 32'(fcnt), 32'd0);
    // Last channels land on the final allowed cycle: completion wins
    i_vld = 4'b0011; tick(); i_vld = 4'h0;
    repeat (15) tick();
    push_exp(1'b0, 0, 4'hF, -1);
    i_vld = 4'b1100; tick(); i_vld = 4'h0;
    chk("t4_late_q_vld", 32'(q_vld), 32'd1);
    chk("t4_late_err", 32'(err), 32'd0);
    tick();
    chk("t4_late_fcnt", 32'(fcnt), 32'd1);

    // T5: masked channels
    mask = 4'b1010;
    #1;
    chk("t5_i_rdy", 32'(i_rdy), 32'b0101);
    i_vld = 4'hF;
    push_exp(1'b0, 1, 4'b0101, -1);
    tick();
    i_vld = 4'h0;
    chk("t5_q_vld", 32'(q_vld), 32'd1);
    tick();
    chk("t5_fcnt", 32'(fcnt), 32'd2);
    chk("t5_i_rdy_after", 32'(i_rdy), 32'b0101);
    mask = 4'hF;
    #1;
    chk("t5_all_masked_i_rdy", 32'(i_rdy), 32'h0);
    i_vld = 4'hF;
    repeat (40) tick();
    chk("t5_all_masked_q_vld", 32'(q_vld), 32'd0);
    chk("t5_all_masked_arr", 32'(arr), 32'h0);
    chk("t5_all_masked_fcnt", 32'(fcnt), 32'd2);
    i_vld = 4'h0;
    mask = 4'h0;
    tick();
    chk("t5_i_rdy_unmask", 32'(i_rdy), 32'hF);

    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
